// File: rtl/cache_pkg.sv
// Shared definitions for the instruction-cache fill controller:
// fill FSM encoding, default block geometry and the word-index type.
package cache_pkg;

    localparam int BLOCK_WORDS_DEF = 8;
    localparam int WORD_IDX_W      = $clog2(BLOCK_WORDS_DEF);
    // byte offset within a block: word index plus the halfword byte bit
    localparam int OFFSET_BITS     = WORD_IDX_W + 1;

    typedef logic [WORD_IDX_W-1:0] word_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } fill_state_t;

endpackage

// File: rtl/fill_cnt.sv
// Loadable wrap counter: a word index that wraps modulo 2**IDX_W and a
// one-bit-wider count of increments since the last load.
module fill_cnt #(
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [IDX_W-1:0] i_load_val,
    input  logic             i_inc,
    output logic [IDX_W-1:0] o_idx,
    output logic [IDX_W:0]   o_cnt
);

    logic [IDX_W-1:0] r_idx;
    logic [IDX_W:0]   r_cnt;

    // load restarts the index at the start word and clears the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_idx <= i_load_val;
            r_cnt <= '0;
        end else if (i_inc) begin
            r_idx <= r_idx + 1'b1;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_idx = r_idx;
    assign o_cnt = r_cnt;

endmodule

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache block fill controller. On a miss it issues one read per
// word of the block on consecutive cycles, writes each in-order response
// into the data array and writes the tag with the last word.
// Optional build macro: ICACHE_CWF_EN (critical word first ordering).
//
// state    | meaning
// ST_IDLE  | no fill; waiting for a miss
// ST_FILL  | issuing requests, collecting responses
// ST_DRAIN | all requests issued, collecting remaining responses
import cache_pkg::*;

module icache_fill_ctrl #(
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
    parameter int ADDR_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           miss_detected,
    input  logic [ADDR_W-1:0]              miss_address,
    input  logic [15:0]                    memory_data,
    input  logic                           memory_data_valid,
    output logic                           fsm_busy,
    output logic                           memory_req,
    output logic [ADDR_W-1:0]              memory_address,
    output logic                           write_data_array,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic [15:0]                    fill_data,
    output logic                           write_tag_array
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W = IDX_W + 1;
    localparam logic [IDX_W:0] LAST_CNT = (IDX_W + 1)'(BLOCK_WORDS - 1);

    fill_state_t             r_state;
    fill_state_t             w_state_nxt;
    logic [ADDR_W-1:OFF_W]   r_base;
    logic                    w_load;
    logic                    w_req_inc;
    logic                    w_rsp_inc;
    logic                    w_req;
    logic                    w_wr;
    logic                    w_tag;
    logic [IDX_W-1:0]        w_start_idx;
    logic [IDX_W-1:0]        w_req_idx;
    logic [IDX_W-1:0]        w_rsp_idx;
    logic [IDX_W:0]          w_req_cnt;
    logic [IDX_W:0]          w_rsp_cnt;
    logic                    w_unused_addr;

`ifdef ICACHE_CWF_EN
    assign w_start_idx = miss_address[OFF_W-1:1];
`else
    assign w_start_idx = '0;
`endif

    // byte-offset bits only feed the start index (or nothing at all)
    assign w_unused_addr = &{1'b0, miss_address[OFF_W-1:0]};

    fill_cnt #(.IDX_W(IDX_W)) u_req_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_start_idx),
        .i_inc      (w_req_inc),
        .o_idx      (w_req_idx),
        .o_cnt      (w_req_cnt)
    );

    fill_cnt #(.IDX_W(IDX_W)) u_rsp_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_start_idx),
        .i_inc      (w_rsp_inc),
        .o_idx      (w_rsp_idx),
        .o_cnt      (w_rsp_cnt)
    );

    // state register and block base captured when a miss is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_base  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_base <= miss_address[ADDR_W-1:OFF_W];
            end
        end
    end

    // next state and strobes; the final response ends the fill in either busy state
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_req       = 1'b0;
        w_req_inc   = 1'b0;
        w_rsp_inc   = 1'b0;
        w_wr        = 1'b0;
        w_tag       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (miss_detected) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                w_req     = 1'b1;
                w_req_inc = 1'b1;
                if (w_req_cnt == LAST_CNT) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_DRAIN;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if ((r_state == ST_FILL || r_state == ST_DRAIN) && memory_data_valid) begin
            w_wr      = 1'b1;
            w_rsp_inc = 1'b1;
            if (w_rsp_cnt == LAST_CNT) begin
                w_tag       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        end
    end

    assign fsm_busy         = (r_state == ST_FILL) || (r_state == ST_DRAIN);
    assign memory_req       = w_req;
    assign memory_address   = {r_base, w_req_idx, 1'b0};
    assign write_data_array = w_wr;
    assign fill_word        = w_rsp_idx;
    assign fill_data        = memory_data;
    assign write_tag_array  = w_tag;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: in-order memory model with configurable
// latency and gaps, expected requests/writes queued per miss.
import cache_pkg::*;

module tb_icache_fill_ctrl;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        word_idx_t   word;
        logic [15:0] data;
        logic        last;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        memory_req;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        write_tag_array;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int lat    = 4;
    bit gap    = 0;
    bit idle_inj = 0;
    int wr_cnt = 0;
    int tag_cnt = 0;
    int busy_cnt = 0;

    mreq_t       mq[$];
    logic [15:0] exp_req[$];
    wr_t         exp_wr[$];

    icache_fill_ctrl #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .memory_req        (memory_req),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word         (fill_word),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic push_fill(input logic [15:0] a);
        logic [15:0] base;
        word_idx_t   idx;
        logic [15:0] ra;
        base = a & ~((16'd1 << OFFSET_BITS) - 16'd1);
`ifdef ICACHE_CWF_EN
        idx = a[OFFSET_BITS-1:1];
`else
        idx = '0;
`endif
        for (int k = 0; k < 8; k++) begin
            ra = base | {12'd0, idx, 1'b0};
            exp_req.push_back(ra);
            exp_wr.push_back('{word: idx, data: mem_word(ra), last: (k == 7)});
            idx = idx + 1'b1;
        end
    endtask

    // memory model: in-order responses, drives inputs just after the edge
    initial begin
        memory_data_valid = 1'b0;
        memory_data       = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            memory_data_valid = 1'b0;
            if (idle_inj) begin
                memory_data_valid = 1'($urandom_range(0, 1));
                memory_data       = 16'($urandom);
            end else if (mq.size() > 0 && mq[0].due <= cyc && (!gap || (cyc % 2 == 0))) begin
                memory_data_valid = 1'b1;
                memory_data       = mem_word(mq[0].addr);
                void'(mq.pop_front());
            end
        end
    end

    // output monitor and scoreboard
    always @(negedge clk) begin
        wr_t w;
        if (fsm_busy === 1'b1) busy_cnt++;
        if (memory_req === 1'b1) begin
            mq.push_back('{addr: memory_address, due: cyc + lat});
            if (exp_req.size() == 0) begin
                chk("unexpected_req", 32'(memory_address), 32'hFFFF_FFFF);
            end else begin
                chk("req_addr", 32'(memory_address), 32'(exp_req.pop_front()));
            end
        end
        if (write_data_array === 1'b1) begin
            wr_cnt++;
            if (exp_wr.size() == 0) begin
                chk("unexpected_write", 32'(fill_word), 32'hFFFF_FFFF);
            end else begin
                w = exp_wr.pop_front();
                chk("fill_word", 32'(fill_word), 32'(w.word));
                chk("fill_data", 32'(fill_data), 32'(w.data));
                chk("tag_with_last", 32'(write_tag_array), 32'(w.last));
            end
        end else if (write_tag_array !== 1'b0) begin
            chk("tag_without_write", 32'(write_tag_array), 32'd0);
        end
        if (write_tag_array === 1'b1) tag_cnt++;
    end

    task automatic wait_busy(input logic val, input int limit, input string tag);
        int n = 0;
        while (fsm_busy !== val && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(fsm_busy), 32'(val));
    endtask

    task automatic run_fill(input logic [15:0] a, input int l, input bit g, input int exp_busy);
        int w0, t0, b0;
        lat = l;
        gap = g;
        push_fill(a);
        w0 = wr_cnt;
        t0 = tag_cnt;
        b0 = busy_cnt;
        @(posedge clk);
        #1;
        miss_address  = a;
        miss_detected = 1'b1;
        @(posedge clk);
        #1;
        miss_detected = 1'b0;
        chk("busy_after_accept", 32'(fsm_busy), 32'd1);
        wait_busy(1'b0, 200, "fill_done");
        chk("fill_writes", 32'(wr_cnt - w0), 32'd8);
        chk("fill_tags", 32'(tag_cnt - t0), 32'd1);
        chk("exp_req_drained", 32'(exp_req.size()), 32'd0);
        chk("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
        if (exp_busy > 0) chk("busy_cycles", 32'(busy_cnt - b0), 32'(exp_busy));
    endtask

    initial begin
        int w0, t0, b0, n, n_low;
        rst_n         = 1'b0;
        miss_detected = 1'b0;
        miss_address  = 16'h0;
        #2;
        chk("rst_busy", 32'(fsm_busy), 32'd0);
        chk("rst_req", 32'(memory_req), 32'd0);
        chk("rst_wr", 32'(write_data_array), 32'd0);
        chk("rst_tag", 32'(write_tag_array), 32'd0);
        chk("rst_fill_word", 32'(fill_word), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // baseline fill, latency 4
        run_fill(16'h1236, 4, 1'b0, 12);
        // short latency, odd address
        run_fill(16'hABCD, 1, 1'b0, 9);
        // top of address space, long latency, responses every other cycle
        run_fill(16'hFFF0, 7, 1'b1, 0);

        // miss held high across completion, address moved during first fill
        lat = 2;
        gap = 1'b0;
        push_fill(16'h0040);
        push_fill(16'h0080);
        w0 = wr_cnt;
        t0 = tag_cnt;
        @(posedge clk);
        #1;
        miss_address  = 16'h0040;
        miss_detected = 1'b1;
        @(posedge clk);
        #1;
        miss_address = 16'h0080;
        n = 0;
        while (tag_cnt != t0 + 1 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("b2b_first_tag", 32'(tag_cnt - t0), 32'd1);
        n_low = 0;
        n = 0;
        while (!(fsm_busy === 1'b1 && n_low > 0) && n < 20) begin
            @(negedge clk);
            #1;
            if (fsm_busy === 1'b0) n_low++;
            n++;
        end
        chk("b2b_idle_cycles", 32'(n_low), 32'd1);
        @(posedge clk);
        #1;
        miss_detected = 1'b0;
        wait_busy(1'b0, 200, "b2b_done");
        chk("b2b_writes", 32'(wr_cnt - w0), 32'd16);
        chk("b2b_tags", 32'(tag_cnt - t0), 32'd2);
        chk("b2b_exp_req_drained", 32'(exp_req.size()), 32'd0);
        chk("b2b_exp_wr_drained", 32'(exp_wr.size()), 32'd0);

        // reset after five responses
        lat = 4;
        push_fill(16'h2000);
        w0 = wr_cnt;
        t0 = tag_cnt;
        @(posedge clk);
        #1;
        miss_address  = 16'h2000;
        miss_detected = 1'b1;
        @(posedge clk);
        #1;
        miss_detected = 1'b0;
        n = 0;
        while (wr_cnt != w0 + 5 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rst_mid_writes", 32'(wr_cnt - w0), 32'd5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(fsm_busy), 32'd0);
        chk("rst_mid_req", 32'(memory_req), 32'd0);
        chk("rst_mid_wr", 32'(write_data_array), 32'd0);
        chk("rst_mid_tag", 32'(write_tag_array), 32'd0);
        chk("rst_mid_fill_word", 32'(fill_word), 32'd0);
        exp_req.delete();
        exp_wr.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            #1;
        end
        chk("rst_late_writes", 32'(wr_cnt - w0), 32'd5);
        chk("rst_no_tag", 32'(tag_cnt - t0), 32'd0);
        chk("rst_idle_busy", 32'(fsm_busy), 32'd0);
        chk("rst_late_rsp_consumed", 32'(mq.size()), 32'd0);

        // valid pulses while idle
        w0 = wr_cnt;
        t0 = tag_cnt;
        b0 = busy_cnt;
        idle_inj = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        idle_inj = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("idle_writes", 32'(wr_cnt - w0), 32'd0);
        chk("idle_tags", 32'(tag_cnt - t0), 32'd0);
        chk("idle_busy", 32'(busy_cnt - b0), 32'd0);

        // normal fill after all of the above
        run_fill(16'h0F0E, 3, 1'b0, 11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
